// File: rtl/floating_point_adder_arbiter.sv
// rtl/floating_point_adder_arbiter.sv - round-robin arbiter sharing one pipelined FP adder
//
// Purpose: NUM_REQ requesters compete round-robin for a single pipelined
// floating-point adder of fixed latency ADDER_LATENCY. The winner's id travels
// beside the operation in a tag shift register and routes the result back as
// a one-hot res_valid_o pulse.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   enable_i                0 blocks new grants; in-flight work still drains
//   req_valid_i/req_ready_o per-requester handshake (ready is one-hot or zero)
//   req_a_i/req_b_i         packed operands, requester k at [k*FPW +: FPW]
//   add_a_o/add_b_o/add_valid_o  registered issue towards the adder
//   add_fp_i/add_valid_i    adder result, ADDER_LATENCY cycles after issue
//   res_fp_o/res_valid_o    routed result, one-hot valid per requester
//   inflight_o              issued operations not yet returned
//   err_o                   sticky: adder valid disagreed with the tag pipe
module floating_point_adder_arbiter #(
  parameter int EXP_WIDTH     = 0,
  parameter int FRAC_WIDTH    = 0,
  parameter int NUM_REQ       = 4,
  parameter int ADDER_LATENCY = 7,
  localparam int FPW          = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*FPW-1:0] req_a_i,
  input  logic [NUM_REQ*FPW-1:0] req_b_i,
  output logic [FPW-1:0]         add_a_o,
  output logic [FPW-1:0]         add_b_o,
  output logic                   add_valid_o,
  input  logic [FPW-1:0]         add_fp_i,
  input  logic                   add_valid_i,
  output logic [FPW-1:0]         res_fp_o,
  output logic [NUM_REQ-1:0]     res_valid_o,
  output logic [4:0]             inflight_o,
  output logic                   err_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]          ptr;
  logic [ID_W-1:0]          ptr_next;
  logic [ID_W-1:0]          grant_id;
  logic [ID_W:0]            cand;
  logic                     grant_found;
  logic                     handshake;
  logic [ID_W-1:0]          add_id;
  logic [ADDER_LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]          tag_id [ADDER_LATENCY];
  logic                     tag_exit_vld;
  logic                     deliver;

  // Search upward from ptr, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid_i[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // The winner always has its valid high, so a grant is itself a handshake.
  assign handshake    = enable_i && grant_found;
  assign req_ready_o  = handshake ? (NUM_REQ'(1) << grant_id) : '0;
  assign ptr_next     = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign tag_exit_vld = tag_vld[ADDER_LATENCY-1];
  // A result is accepted only when adder and tag pipe agree.
  assign deliver      = tag_exit_vld && add_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr         <= '0;
      add_valid_o <= 1'b0;
      tag_vld     <= '0;
      res_valid_o <= '0;
      inflight_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      add_valid_o <= handshake;
      if (handshake) ptr <= ptr_next;

      for (int i = ADDER_LATENCY - 1; i > 0; i--) tag_vld[i] <= tag_vld[i-1];
      tag_vld[0] <= add_valid_o;

      res_valid_o <= deliver ? (NUM_REQ'(1) << tag_id[ADDER_LATENCY-1]) : '0;
      if (tag_exit_vld != add_valid_i) err_o <= 1'b1;

      // Issue and retire in the same cycle cancel out.
      case ({add_valid_o, tag_exit_vld})
        2'b10:   inflight_o <= inflight_o + 5'd1;
        2'b01:   inflight_o <= inflight_o - 5'd1;
        default: inflight_o <= inflight_o;
      endcase
    end
  end

  // Datapath registers carry no reset; their valids qualify them.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      add_a_o <= req_a_i[grant_id*FPW +: FPW];
      add_b_o <= req_b_i[grant_id*FPW +: FPW];
      add_id  <= grant_id;
    end
    for (int i = ADDER_LATENCY - 1; i > 0; i--) tag_id[i] <= tag_id[i-1];
    tag_id[0] <= add_id;
    if (deliver) res_fp_o <= add_fp_i;
  end

endmodule

// File: tb/tb_floating_point_adder_arbiter.sv
// tb/tb_floating_point_adder_arbiter.sv - directed self-checking bench for floating_point_adder_arbiter
module tb_floating_point_adder_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic         add_valid;
  logic [31:0]  add_fp;
  logic         add_valid_in;
  logic         inject;
  logic [31:0]  res_fp;
  logic [3:0]   res_valid;
  logic [4:0]   inflight;
  logic         err;

  floating_point_adder_arbiter #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .NUM_REQ(NR), .ADDER_LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .add_a_o(add_a), .add_b_o(add_b), .add_valid_o(add_valid),
    .add_fp_i(add_fp), .add_valid_i(add_valid_in),
    .res_fp_o(res_fp), .res_valid_o(res_valid),
    .inflight_o(inflight), .err_o(err)
  );

  always #5 clk = ~clk;

  // Requester k adds 1.0 + OP_B[k]; hand-computed sums in EXP_RES.
  localparam logic [31:0] OP_A = 32'h3F800000;
  localparam logic [31:0] OP_B [4] = '{32'h3F800000, 32'h40800000, 32'h40000000, 32'h40400000};
  localparam logic [31:0] EXP_RES [4] = '{32'h40000000, 32'h40A00000, 32'h40400000, 32'h40800000};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Positive normal single-precision add, truncating.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, et;
    logic [24:0] ma, mb, mt;
    ea = a[30:23]; eb = b[30:23];
    ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
    if (ea < eb) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    mb = mb >> (ea - eb);
    mt = ma + mb;
    if (mt[24]) begin
      mt = mt >> 1;
      ea = ea + 8'd1;
    end
    return {1'b0, ea, mt[22:0]};
  endfunction

  // Behavioural adder, flushed by the same reset as the DUT.
  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else begin
      pv    <= {pv[LAT-2:0], add_valid};
      pd[0] <= fp_add(add_a, add_b);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign add_valid_in = pv[LAT-1] | inject;
  assign add_fp       = pd[LAT-1];

  // Scoreboard: grants observed mid-cycle, results popped in order.
  int sb_q [$];
  int glog [$];
  int res_cnt = 0;
  int max_inflight = 0;
  always @(negedge clk) begin
    if (!rst_n) sb_q.delete();
    else begin
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
      if (res_valid != 4'b0) begin
        res_cnt++;
        if (sb_q.size() == 0) check_eq("res_spurious", 32'(res_valid), 32'h0);
        else begin
          int id;
          id = sb_q.pop_front();
          check_eq("res_onehot", 32'(res_valid), 32'(1) << id);
          check_eq("res_fp", res_fp, EXP_RES[id]);
        end
      end
      for (int k = 0; k < NR; k++)
        if (req_valid[k] && req_ready[k]) begin
          sb_q.push_back(k);
          glog.push_back(k);
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; enable = 1'b0; req_valid = 4'b0; inject = 1'b0;
    for (int k = 0; k < NR; k++) begin
      req_a[k*32 +: 32] = OP_A;
      req_b[k*32 +: 32] = OP_B[k];
    end

    // Reset state, before any clock edge
    #1;
    check_eq("rst_add_valid", 32'(add_valid), 32'h0);
    check_eq("rst_res_valid", 32'(res_valid), 32'h0);
    check_eq("rst_inflight", 32'(inflight), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // All four valid continuously: order 0,1,2,3,..., full rate, saturation at 7
    glog.delete();
    enable = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("full_rate_add_valid", 32'(add_valid), 32'h1);
    end
    req_valid = 4'b0;
    for (int i = 0; i < 13; i++) tick();
    check_eq("full_grant_count", glog.size(), 12);
    for (int i = 0; i < 12 && i < glog.size(); i++) check_eq("rr_order", glog[i], i % 4);
    check_eq("inflight_sat", max_inflight, 7);
    check_eq("full_drained", 32'(inflight), 32'h0);

    // Single request on requester 2, end-to-end latency
    glog.delete();
    req_valid = 4'b0100;
    #1;
    check_eq("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0;
    check_eq("single_add_valid", 32'(add_valid), 32'h1);
    check_eq("single_add_a", add_a, 32'h3F800000);
    check_eq("single_add_b", add_b, 32'h40000000);
    #1;
    check_eq("idle_ready", 32'(req_ready), 32'h0);
    n = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (res_valid != 4'b0) begin found = 1'b1; n = i; end
    end
    // add_valid_o after the handshake edge, adder output LAT later, result one more
    check_eq("latency_edges", n, LAT + 1);
    check_eq("single_res_valid", 32'(res_valid), 32'h4);
    check_eq("single_res_fp", res_fp, 32'h40400000);
    tick();
    check_eq("single_res_pulse", 32'(res_valid), 32'h0);

    // Move ptr to 2, then requesters 1 and 3: expect 3,1,3
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0;
    tick();
    glog.delete();
    req_valid = 4'b1010;
    tick(); tick(); tick();
    req_valid = 4'b0;
    check_eq("rr_skip_count", glog.size(), 3);
    if (glog.size() == 3) begin
      check_eq("rr_skip_0", glog[0], 3);
      check_eq("rr_skip_1", glog[1], 1);
      check_eq("rr_skip_2", glog[2], 3);
    end
    for (int i = 0; i < 12; i++) tick();

    // Enable dropped with three in flight
    res_cnt = 0;
    req_valid = 4'b1111;
    tick(); tick(); tick();
    enable = 1'b0;
    #1;
    check_eq("disable_ready", 32'(req_ready), 32'h0);
    tick();
    check_eq("disable_add_valid", 32'(add_valid), 32'h0);
    check_eq("disable_inflight", 32'(inflight), 32'h3);
    for (int i = 0; i < 15; i++) tick();
    check_eq("disable_results", res_cnt, 3);
    check_eq("disable_drained", 32'(inflight), 32'h0);

    // Reset mid-stream with five operations in flight
    enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("pre_reset_inflight", 32'(inflight), 32'h5);
    rst_n = 1'b0;
    #1;
    check_eq("async_add_valid", 32'(add_valid), 32'h0);
    check_eq("async_inflight", 32'(inflight), 32'h0);
    check_eq("async_res_valid", 32'(res_valid), 32'h0);
    req_valid = 4'b0;
    tick(); tick();
    res_cnt = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("post_reset_results", res_cnt, 0);
    check_eq("post_reset_err", 32'(err), 32'h0);

    // Stray adder valid with nothing in flight
    res_cnt = 0;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check_eq("err_set", 32'(err), 32'h1);
    check_eq("err_no_result", 32'(res_valid), 32'h0);
    tick(); tick(); tick();
    check_eq("err_sticky", 32'(err), 32'h1);
    check_eq("err_results", res_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
